// File: rtl/fat_page_writer_if.sv
// Block-write bus between the FAT page writer (master) and the SD block-write engine (slave).
// Carries the address request handshake, the byte stream and the programming-done pulse.
interface fat_page_writer_if;
    logic        WR_REQ;
    logic [31:0] WR_ADDR;
    logic        WR_ACK;
    logic [7:0]  DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        WR_DONE;

    modport master (
        output WR_REQ, WR_ADDR, DATA, DATA_VALID,
        input  WR_ACK, DATA_READY, WR_DONE
    );

    modport slave (
        input  WR_REQ, WR_ADDR, DATA, DATA_VALID,
        output WR_ACK, DATA_READY, WR_DONE
    );
endinterface

// File: rtl/fat_page_writer.sv
// Builds one 512-byte FAT32 sector for a single contiguous cluster chain and writes it
// to the SD block-write engine twice: first to the FAT1 block, then to the FAT2 block.
module fat_page_writer #(
    parameter logic [31:0] FILE_FIRST_CLUST = 32'd4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [31:0]           FIRST_CLUST,
    input  logic [31:0]           CLUST_EOF,
    input  logic [31:0]           FAT1_ADDR,
    input  logic [31:0]           FAT2_ADDR,
    fat_page_writer_if.master     wr,
    output logic                  BUSY,
    output logic                  COMPLT
);

    typedef enum logic [2:0] {
        IDLE, REQ1, STREAM1, WAIT1, REQ2, STREAM2, WAIT2, DONE
    } state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [31:0] base_q, base_d;
    logic [31:0] eof_q, eof_d;
    logic [31:0] fat1_q, fat1_d;
    logic [31:0] fat2_q, fat2_d;
    logic [8:0]  cnt_q, cnt_d;
    logic        wr_req_q, wr_req_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [7:0]  data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        busy_q, busy_d;
    logic        complt_q, complt_d;

    logic        start_edge;
    logic        load_byte;
    logic [31:0] entry_n;
    logic [31:0] entry_val;

    // The first matching rule wins, so the system-chain rule only ever sees n >= 2.
    function automatic logic [31:0] entry_value(input logic [31:0] n, input logic [31:0] eof);
        logic [31:0] v;
        if (n == 32'd0)
            v = 32'h0FFF_FFF8;
        else if (n == 32'd1)
            v = 32'hFFFF_FFFF;
        else if (n < FILE_FIRST_CLUST)
            v = 32'h0FFF_FFFF;
        else if (n < eof)
            v = (n + 32'd1) & 32'h0FFF_FFFF;
        else if (n == eof)
            v = 32'h0FFF_FFFF;
        else
            v = 32'h0000_0000;
        return v;
    endfunction

    always_comb begin
        state_d      = state_q;
        start_d      = START;
        base_d       = base_q;
        eof_d        = eof_q;
        fat1_d       = fat1_q;
        fat2_d       = fat2_q;
        cnt_d        = cnt_q;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;
        busy_d       = busy_q;
        complt_d     = complt_q;
        load_byte    = 1'b0;
        start_edge   = START & ~start_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_d   = REQ1;
                    base_d    = FIRST_CLUST - 32'd1;
                    eof_d     = CLUST_EOF;
                    fat1_d    = FAT1_ADDR;
                    fat2_d    = FAT2_ADDR;
                    wr_req_d  = 1'b1;
                    wr_addr_d = FAT1_ADDR;
                    busy_d    = 1'b1;
                    complt_d  = 1'b0;
                end
            end
            REQ1, REQ2: begin
                if (wr.WR_ACK) begin
                    state_d      = (state_q == REQ1) ? STREAM1 : STREAM2;
                    wr_req_d     = 1'b0;
                    cnt_d        = 9'd0;
                    data_valid_d = 1'b1;
                    load_byte    = 1'b1;
                end
            end
            STREAM1, STREAM2: begin
                if (data_valid_q && wr.DATA_READY) begin
                    if (cnt_q == 9'd511) begin
                        data_valid_d = 1'b0;
                        state_d      = (state_q == STREAM1) ? WAIT1 : WAIT2;
                    end else begin
                        cnt_d     = cnt_q + 9'd1;
                        load_byte = 1'b1;
                    end
                end
            end
            WAIT1: begin
                if (wr.WR_DONE) begin
                    state_d   = REQ2;
                    wr_req_d  = 1'b1;
                    wr_addr_d = fat2_q;
                end
            end
            WAIT2: begin
                if (wr.WR_DONE) begin
                    state_d  = DONE;
                    busy_d   = 1'b0;
                    complt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The byte for the next counter value is formed here so DATA leaves a flop.
        entry_n   = base_q + {25'd0, cnt_d[8:2]};
        entry_val = entry_value(entry_n, eof_q);
        if (load_byte) begin
            case (cnt_d[1:0])
                2'd0:    data_d = entry_val[7:0];
                2'd1:    data_d = entry_val[15:8];
                2'd2:    data_d = entry_val[23:16];
                default: data_d = entry_val[31:24];
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            base_q       <= 32'd0;
            eof_q        <= 32'd0;
            fat1_q       <= 32'd0;
            fat2_q       <= 32'd0;
            cnt_q        <= 9'd0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= 32'd0;
            data_q       <= 8'd0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            complt_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start_d;
            base_q       <= base_d;
            eof_q        <= eof_d;
            fat1_q       <= fat1_d;
            fat2_q       <= fat2_d;
            cnt_q        <= cnt_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            complt_q     <= complt_d;
        end
    end

    assign wr.WR_REQ     = wr_req_q;
    assign wr.WR_ADDR    = wr_addr_q;
    assign wr.DATA       = data_q;
    assign wr.DATA_VALID = data_valid_q;
    assign BUSY          = busy_q;
    assign COMPLT        = complt_q;

endmodule

// File: tb/tb_fat_page_writer.sv
// Self-checking bench for fat_page_writer: a scoreboard queue of expected sector bytes is
// filled when an operation starts and drained by a monitor on every accepted byte.
module tb_fat_page_writer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [31:0] FIRST_CLUST;
    logic [31:0] CLUST_EOF;
    logic [31:0] FAT1_ADDR;
    logic [31:0] FAT2_ADDR;
    logic        BUSY;
    logic        COMPLT;

    fat_page_writer_if wr();

    fat_page_writer dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .FIRST_CLUST (FIRST_CLUST),
        .CLUST_EOF   (CLUST_EOF),
        .FAT1_ADDR   (FAT1_ADDR),
        .FAT2_ADDR   (FAT2_ADDR),
        .wr          (wr),
        .BUSY        (BUSY),
        .COMPLT      (COMPLT)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int          xfer_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  cap[0:1023];
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    // Sampling on the falling edge sees exactly what the DUT will accept at the next rising edge.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (!RST && wr.DATA_VALID) begin
            if (prev_stall) begin
                checks++;
                if (wr.DATA !== prev_data) begin
                    failures++;
                    $display("[TB] FAIL data_stable got=%02h want=%02h", wr.DATA, prev_data);
                end
            end
            if (wr.DATA_READY) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_byte got=%02h want=none", wr.DATA);
                end else begin
                    e = exp_q.pop_front();
                    if (wr.DATA !== e) begin
                        failures++;
                        $display("[TB] FAIL byte[%0d] got=%02h want=%02h", xfer_cnt, wr.DATA, e);
                    end
                end
                if (xfer_cnt < 1024) cap[xfer_cnt] = wr.DATA;
                xfer_cnt++;
            end
            prev_stall = !wr.DATA_READY;
            prev_data  = wr.DATA;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] model_entry(input logic [31:0] first, input logic [31:0] eof, input int i);
        logic [31:0] n;
        n = first - 32'd1 + 32'(i);
        if (n == 32'd0) return 32'h0FFF_FFF8;
        if (n == 32'd1) return 32'hFFFF_FFFF;
        if (n < 32'd4) return 32'h0FFF_FFFF;
        if (n < eof) return (n + 32'd1) & 32'h0FFF_FFFF;
        if (n == eof) return 32'h0FFF_FFFF;
        return 32'h0000_0000;
    endfunction

    function automatic logic [31:0] cap_entry(input int i);
        return {cap[4*i+3], cap[4*i+2], cap[4*i+1], cap[4*i]};
    endfunction

    task automatic push_model(input logic [31:0] first, input logic [31:0] eof);
        logic [31:0] w;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 128; i++) begin
                w = model_entry(first, eof, i);
                for (int l = 0; l < 4; l++) exp_q.push_back(w[8*l +: 8]);
            end
    endtask

    task automatic start_op(input logic [31:0] first, input logic [31:0] eof,
                            input logic [31:0] f1, input logic [31:0] f2);
        FIRST_CLUST = first;
        CLUST_EOF   = eof;
        FAT1_ADDR   = f1;
        FAT2_ADDR   = f2;
        START       = 1'b1;
        step();
        START       = 1'b0;
    endtask

    // Plays the block-write engine for one sector: accept, stream, then signal programming done.
    task automatic serve_copy(input int ack_delay, input bit rnd_ready,
                              output logic [31:0] got_addr, output bit timed_out, output int valid_cycles);
        timed_out    = 1'b0;
        valid_cycles = 0;
        got_addr     = 32'hDEAD_BEEF;
        for (int t = 0; t < 200 && !wr.WR_REQ; t++) step();
        if (!wr.WR_REQ) begin
            timed_out = 1'b1;
            return;
        end
        got_addr = wr.WR_ADDR;
        repeat (ack_delay) step();
        wr.WR_ACK = 1'b1;
        step();
        wr.WR_ACK = 1'b0;
        for (int t = 0; t < 5000 && wr.DATA_VALID; t++) begin
            wr.DATA_READY = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            step();
            valid_cycles++;
        end
        if (wr.DATA_VALID) timed_out = 1'b1;
        wr.DATA_READY = 1'b0;
        repeat (3) step();
        wr.WR_DONE = 1'b1;
        step();
        wr.WR_DONE = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] first, input logic [31:0] eof,
                          input logic [31:0] f1, input logic [31:0] f2,
                          input int ack_delay, input bit rnd_ready,
                          output logic [31:0] a1, output logic [31:0] a2, output bit to);
        bit t1, t2;
        int vc;
        exp_q.delete();
        xfer_cnt = 0;
        push_model(first, eof);
        start_op(first, eof, f1, f2);
        serve_copy(ack_delay, rnd_ready, a1, t1, vc);
        serve_copy(ack_delay, rnd_ready, a2, t2, vc);
        to = t1 | t2;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        START = 1'b0;
        FIRST_CLUST = 32'd0; CLUST_EOF = 32'd0; FAT1_ADDR = 32'd0; FAT2_ADDR = 32'd0;
        wr.WR_ACK = 1'b0; wr.DATA_READY = 1'b0; wr.WR_DONE = 1'b0;
        repeat (3) step();
        checks++; if (wr.WR_REQ !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_req got=%0h want=0", wr.WR_REQ); end
        checks++; if (wr.WR_ADDR !== 32'd0) begin failures++; $display("[TB] FAIL reset_wr_addr got=%0h want=0", wr.WR_ADDR); end
        checks++; if (wr.DATA !== 8'd0) begin failures++; $display("[TB] FAIL reset_data got=%0h want=0", wr.DATA); end
        checks++; if (wr.DATA_VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_data_valid got=%0h want=0", wr.DATA_VALID); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0h want=0", BUSY); end
        checks++; if (COMPLT !== 1'b0) begin failures++; $display("[TB] FAIL reset_complt got=%0h want=0", COMPLT); end
        RST = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_basic_sector();
        logic [31:0] tbl[128];
        logic [31:0] a;
        logic [7:0]  hdr[8];
        bit          to;
        int          vc;
        hdr = '{8'hF8, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int i = 0; i < 128; i++) tbl[i] = 32'd0;
        tbl[0] = 32'h0FFF_FFF8; tbl[1] = 32'hFFFF_FFFF; tbl[2] = 32'h0FFF_FFFF; tbl[3] = 32'h0FFF_FFFF;
        tbl[4] = 32'h0000_0005; tbl[5] = 32'h0000_0006; tbl[6] = 32'h0FFF_FFFF;
        exp_q.delete();
        xfer_cnt = 0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 128; i++)
                for (int l = 0; l < 4; l++) exp_q.push_back(tbl[i][8*l +: 8]);

        start_op(32'd1, 32'd6, 32'h100, 32'h2000);
        checks++; if (wr.WR_REQ !== 1'b1) begin failures++; $display("[TB] FAIL start_wr_req got=%0h want=1", wr.WR_REQ); end
        checks++; if (wr.WR_ADDR !== 32'h100) begin failures++; $display("[TB] FAIL start_wr_addr got=%0h want=100", wr.WR_ADDR); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("[TB] FAIL start_busy got=%0h want=1", BUSY); end
        checks++; if (COMPLT !== 1'b0) begin failures++; $display("[TB] FAIL start_complt got=%0h want=0", COMPLT); end
        FIRST_CLUST = 32'h7777_0000; CLUST_EOF = 32'd2; FAT1_ADDR = 32'h999; FAT2_ADDR = 32'h888;

        serve_copy(0, 1'b0, a, to, vc);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL basic_copy1_timeout got=%0h want=0", to); end
        checks++; if (a !== 32'h100) begin failures++; $display("[TB] FAIL basic_addr1 got=%0h want=100", a); end
        checks++; if (vc != 512) begin failures++; $display("[TB] FAIL basic_stream_cycles got=%0d want=512", vc); end
        checks++; if (xfer_cnt != 512) begin failures++; $display("[TB] FAIL basic_xfers1 got=%0d want=512", xfer_cnt); end
        checks++; if (wr.WR_REQ !== 1'b1) begin failures++; $display("[TB] FAIL basic_req2 got=%0h want=1", wr.WR_REQ); end
        checks++; if (COMPLT !== 1'b0) begin failures++; $display("[TB] FAIL basic_complt_early got=%0h want=0", COMPLT); end

        serve_copy(0, 1'b0, a, to, vc);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL basic_copy2_timeout got=%0h want=0", to); end
        checks++; if (a !== 32'h2000) begin failures++; $display("[TB] FAIL basic_addr2 got=%0h want=2000", a); end
        checks++; if (xfer_cnt != 1024) begin failures++; $display("[TB] FAIL basic_xfers2 got=%0d want=1024", xfer_cnt); end
        checks++; if (COMPLT !== 1'b1) begin failures++; $display("[TB] FAIL basic_complt got=%0h want=1", COMPLT); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_done got=%0h want=0", BUSY); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap[i] !== hdr[i]) begin failures++; $display("[TB] FAIL basic_hdr[%0d] got=%02h want=%02h", i, cap[i], hdr[i]); end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL basic_leftover got=%0d want=0", exp_q.size()); end
        repeat (5) step();
        checks++; if (COMPLT !== 1'b1) begin failures++; $display("[TB] FAIL basic_complt_hold got=%0h want=1", COMPLT); end
    endtask

    task automatic test_mid_page();
        logic [31:0] a1, a2;
        bit to;
        int bad;
        run_op(32'd129, 32'd300, 32'h5000, 32'h6000, 0, 1'b0, a1, a2, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL mid_timeout got=%0h want=0", to); end
        checks++; if (cap_entry(0) !== 32'h81) begin failures++; $display("[TB] FAIL mid_entry0 got=%0h want=81", cap_entry(0)); end
        checks++; if (cap_entry(127) !== 32'h100) begin failures++; $display("[TB] FAIL mid_entry127 got=%0h want=100", cap_entry(127)); end
        bad = 0;
        for (int i = 0; i < 128; i++)
            if (cap_entry(i) == 32'h0FFF_FFFF || cap_entry(i) == 32'd0) bad++;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL mid_eof_or_zero got=%0d want=0", bad); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL mid_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_eof_in_page();
        logic [31:0] a1, a2;
        bit to;
        int bad;
        run_op(32'd257, 32'd300, 32'h7000, 32'h8000, 0, 1'b0, a1, a2, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL eof_timeout got=%0h want=0", to); end
        checks++; if (cap_entry(43) !== 32'h12C) begin failures++; $display("[TB] FAIL eof_entry43 got=%0h want=12c", cap_entry(43)); end
        checks++; if (cap_entry(44) !== 32'h0FFF_FFFF) begin failures++; $display("[TB] FAIL eof_entry44 got=%0h want=fffffff", cap_entry(44)); end
        bad = 0;
        for (int i = 45; i < 128; i++) if (cap_entry(i) != 32'd0) bad++;
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL eof_tail_nonzero got=%0d want=0", bad); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL eof_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_random_ready();
        logic [31:0] a1, a2;
        bit to;
        int diff;
        run_op(32'd3, 32'd200, 32'h55, 32'h66, 5, 1'b1, a1, a2, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL rnd_timeout got=%0h want=0", to); end
        checks++; if (a1 !== 32'h55 || a2 !== 32'h66) begin failures++; $display("[TB] FAIL rnd_addrs got=%0h/%0h want=55/66", a1, a2); end
        checks++; if (xfer_cnt != 1024) begin failures++; $display("[TB] FAIL rnd_xfers got=%0d want=1024", xfer_cnt); end
        diff = 0;
        for (int i = 0; i < 512; i++) if (cap[i] !== cap[512+i]) diff++;
        checks++; if (diff != 0) begin failures++; $display("[TB] FAIL rnd_copy_diff got=%0d want=0", diff); end
        checks++; if (COMPLT !== 1'b1) begin failures++; $display("[TB] FAIL rnd_complt got=%0h want=1", COMPLT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL rnd_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a1, a2;
        bit to;
        fork
            run_op(32'd1, 32'd10, 32'hA0, 32'hB0, 0, 1'b0, a1, a2, to);
            begin
                step();
                for (int t = 0; t < 3000 && xfer_cnt < 100; t++) step();
                START = 1'b1;
                step();
                step();
                START = 1'b0;
            end
        join
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL glitch_timeout got=%0h want=0", to); end
        checks++; if (xfer_cnt != 1024) begin failures++; $display("[TB] FAIL glitch_xfers got=%0d want=1024", xfer_cnt); end
        checks++; if (COMPLT !== 1'b1) begin failures++; $display("[TB] FAIL glitch_complt got=%0h want=1", COMPLT); end
        repeat (10) step();
        checks++; if (wr.WR_REQ !== 1'b0) begin failures++; $display("[TB] FAIL glitch_extra_req got=%0h want=0", wr.WR_REQ); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy got=%0h want=0", BUSY); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL glitch_leftover got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a1, a2;
        bit to;
        exp_q.delete();
        xfer_cnt = 0;
        push_model(32'd1, 32'd6);
        start_op(32'd1, 32'd6, 32'h100, 32'h2000);
        for (int t = 0; t < 50 && !wr.WR_REQ; t++) step();
        wr.WR_ACK = 1'b1;
        step();
        wr.WR_ACK = 1'b0;
        wr.DATA_READY = 1'b1;
        for (int t = 0; t < 1000 && xfer_cnt < 200; t++) step();
        checks++; if (xfer_cnt != 200) begin failures++; $display("[TB] FAIL rstmid_reach got=%0d want=200", xfer_cnt); end
        RST = 1'b1;
        #1;
        checks++; if (wr.WR_REQ !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_wr_req got=%0h want=0", wr.WR_REQ); end
        checks++; if (wr.WR_ADDR !== 32'd0) begin failures++; $display("[TB] FAIL rstmid_wr_addr got=%0h want=0", wr.WR_ADDR); end
        checks++; if (wr.DATA !== 8'd0) begin failures++; $display("[TB] FAIL rstmid_data got=%0h want=0", wr.DATA); end
        checks++; if (wr.DATA_VALID !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%0h want=0", wr.DATA_VALID); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%0h want=0", BUSY); end
        checks++; if (COMPLT !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_complt got=%0h want=0", COMPLT); end
        exp_q.delete();
        wr.DATA_READY = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        repeat (2) step();
        run_op(32'd5, 32'd40, 32'h300, 32'h400, 0, 1'b0, a1, a2, to);
        checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL restart_timeout got=%0h want=0", to); end
        checks++; if (a1 !== 32'h300 || a2 !== 32'h400) begin failures++; $display("[TB] FAIL restart_addrs got=%0h/%0h want=300/400", a1, a2); end
        checks++; if (cap[0] !== 8'h05) begin failures++; $display("[TB] FAIL restart_byte0 got=%02h want=05", cap[0]); end
        checks++; if (xfer_cnt != 1024) begin failures++; $display("[TB] FAIL restart_xfers got=%0d want=1024", xfer_cnt); end
        checks++; if (COMPLT !== 1'b1) begin failures++; $display("[TB] FAIL restart_complt got=%0h want=1", COMPLT); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL restart_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_sector();
        test_mid_page();
        test_eof_in_page();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fat_page_writer.md
# fat_page_writer

Downstream of the file-system server: takes the FAT page geometry it computes (first cluster of the FAT page to update, end-of-file cluster, FAT1/FAT2 block addresses) and produces one 512-byte FAT32 sector describing a single contiguous cluster chain. The block writes that sector twice to the SD block-write engine, first to FAT1 and then to FAT2. It signals completion so the controller can proceed to the directory-entry update.

## Interface
- FILE_FIRST_CLUST, 4, first cluster of the file chain; clusters 2..FILE_FIRST_CLUST-1 are single-cluster system chains.
- CLK  input  1  clock; all logic on posedge.
- RST  input  1  reset, asynchronous, active-high.
- START  input  1  level request; operation begins on its rising edge, detected against a registered copy.
- FIRST_CLUST  input  32  first cluster to update FAT, as produced upstream (page base cluster + 1).
- CLUST_EOF  input  32  cluster number holding the end-of-chain marker.
- FAT1_ADDR, FAT2_ADDR  input  32 each  SD block addresses of the FAT1/FAT2 page.
- WR_REQ  output  1  block-write request.
- WR_ADDR  output  32  block address, valid while WR_REQ=1.
- WR_ACK  input  1  engine accepts the request.
- DATA  output  8  sector byte.
- DATA_VALID  output  1  DATA is valid.
- DATA_READY  input  1  engine consumes DATA.
- WR_DONE  input  1  one-cycle pulse when the engine has finished programming the block.
- BUSY  output  1  operation in progress.
- COMPLT  output  1  both copies written.

## Operation
- On the START rising edge in IDLE, latch base = FIRST_CLUST-1, CLUST_EOF, FAT1_ADDR and FAT2_ADDR. Later input changes are ignored until the next start.
- States and transitions:
  - IDLE → REQ1 on START edge.
  - REQ1 → STREAM1 on WR_ACK.
  - STREAM1 → WAIT1 after byte 511 transfers.
  - WAIT1 → REQ2 on WR_DONE.
  - REQ2 → STREAM2 on WR_ACK.
  - STREAM2 → WAIT2 after byte 511 transfers.
  - WAIT2 → DONE on WR_DONE.
  - DONE → REQ1 on a new START edge.
- REQ1/REQ2: WR_REQ=1, WR_ADDR=FAT1/FAT2 address. STREAMx: DATA_VALID=1.
- Byte counter 0..511: entry i = cnt[8:2], byte lane = cnt[1:0], little-endian (lane 0 = bits 7:0). The counter resets to 0 on entering each STREAM state.
- Entry value for cluster n = base + i. The first matching rule applies:
  - n=0 → 0x0FFFFFF8.
  - n=1 → 0xFFFFFFFF.
  - 2 ≤ n < FILE_FIRST_CLUST → 0x0FFFFFFF.
  - FILE_FIRST_CLUST ≤ n < CLUST_EOF → (n+1) & 0x0FFFFFFF.
  - n = CLUST_EOF → 0x0FFFFFFF.
  - n > CLUST_EOF → 0x00000000.
- All comparisons are unsigned 32-bit. base+i uses 32-bit wraparound (no overflow detection).
- FAT2 content is byte-identical to FAT1.
- START edges outside IDLE/DONE are ignored. Spurious WR_ACK/WR_DONE outside the matching state are ignored.
- RST mid-operation aborts immediately to IDLE. A partially written sector is the controller's concern.

## Timing
- Reset values: WR_REQ=0, WR_ADDR=0, DATA=0, DATA_VALID=0, BUSY=0, COMPLT=0, state IDLE, counter 0.
- Edge cycle k (START=1, registered copy 0): at posedge k+1, WR_REQ=1, WR_ADDR=FAT1_ADDR, BUSY=1, COMPLT=0.
- WR_ACK high at a posedge drops WR_REQ and raises DATA_VALID with byte 0 in the following cycle.
- A byte transfers on each posedge with DATA_VALID & DATA_READY. DATA is held stable while DATA_READY=0.
- Minimum stream time is 512 cycles; DATA_VALID drops the cycle after byte 511.
- WR_DONE → REQ2 (WR_REQ=1) in the next cycle.
- After the final WR_DONE, the next cycle has COMPLT=1 and BUSY=0. COMPLT stays high until a new START edge or RST.
- All outputs are registered. DATA for the current counter value is computed combinationally, then registered.

## Test plan
- FIRST_CLUST=1, CLUST_EOF=6, FAT1=0x100, FAT2=0x2000, ready always 1:
  - WR_ADDR 0x100 then 0x2000.
  - Bytes 0..7 = F8 FF FF 0F FF FF FF FF.
  - Entries 2,3 = 0x0FFFFFFF; entry4 = 05 00 00 00; entry5 = 06 00 00 00; entry6 = FF FF FF 0F.
  - Entries 7..127 = 0.
  - COMPLT one cycle after the second WR_DONE.
- FIRST_CLUST=129, CLUST_EOF=300: entry0 = 0x81, entry127 = 0x100, no EOF or zero entries.
- FIRST_CLUST=257, CLUST_EOF=300: entry43 = 0x12C, entry44 = 0x0FFFFFFF, entry45..127 = 0.
- DATA_READY random 50% with WR_ACK delayed 5 cycles: DATA stable while stalled; exactly 512 transfers per copy; both copies identical.
- START pulsed again during STREAM1: ignored; a single two-sector operation completes.
- RST asserted at byte 200 of FAT1: all outputs 0 within the same cycle. A subsequent START restarts cleanly from REQ1 with byte 0.
